// File: rtl/acc_alu_if.sv
// Command/result bundle for the accumulator ALU.
// The master side issues commands and the slave side (the ALU) returns
// the accumulator, the status flags and the handshake.
interface acc_alu_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] acc_out;
   logic             out_valid;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, op, operand,
      input  in_ready, acc_out, out_valid, zero, carry, overflow, busy
   );

   modport slave (
      input  in_valid, op, operand,
      output in_ready, acc_out, out_valid, zero, carry, overflow, busy
   );
endinterface

// File: rtl/acc_alu.sv
// Accumulator ALU with status flags and an optional shift-add multiplier.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a command; single-cycle ops complete on acceptance
// ST_MUL  | shift-add multiply running, one multiplier bit per cycle;
//         | acc_out and flags keep their pre-multiply values
module acc_alu #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input logic       clk,
   input logic       rst_n,
   acc_alu_if.slave  bus
);
   localparam int CW     = $clog2(WIDTH) + 1;
   localparam bit MUL_ON = (MUL_EN != 0);

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   logic               accept;
   logic               wr_acc;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [2*WIDTH-1:0] prod_next;

   assign accept    = bus.in_valid && (state_q == ST_IDLE);
   // The extra top bit of sub_full is the unsigned borrow.
   assign add_full  = {1'b0, acc_q} + {1'b0, bus.operand};
   assign sub_full  = {1'b0, acc_q} - {1'b0, bus.operand};
   assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.busy      = (state_q == ST_MUL);
   assign bus.acc_out   = acc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = ovf_q;

   // Next-state, datapath and flag computation.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      prod_d      = prod_q;
      mplier_d    = mplier_q;
      wr_acc      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               out_valid_d = 1'b1;
               case (bus.op)
                  OP_CLR: begin
                     acc_d   = '0;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                     wr_acc  = 1'b1;
                  end
                  OP_ADD: begin
                     acc_d   = add_full[WIDTH-1:0];
                     carry_d = add_full[WIDTH];
                     ovf_d   = (acc_q[WIDTH-1] == bus.operand[WIDTH-1]) &&
                               (add_full[WIDTH-1] != acc_q[WIDTH-1]);
                     wr_acc  = 1'b1;
                  end
                  OP_SUB: begin
                     acc_d   = sub_full[WIDTH-1:0];
                     carry_d = sub_full[WIDTH];
                     ovf_d   = (acc_q[WIDTH-1] != bus.operand[WIDTH-1]) &&
                               (sub_full[WIDTH-1] != acc_q[WIDTH-1]);
                     wr_acc  = 1'b1;
                  end
                  OP_LOAD: begin
                     acc_d   = bus.operand;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                     wr_acc  = 1'b1;
                  end
                  OP_AND: begin
                     acc_d   = acc_q & bus.operand;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                     wr_acc  = 1'b1;
                  end
                  OP_OR: begin
                     acc_d   = acc_q | bus.operand;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                     wr_acc  = 1'b1;
                  end
                  OP_MUL: begin
                     // Without the multiplier this falls through as a NOP.
                     if (MUL_ON) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_MUL;
                        mcand_d     = {{WIDTH{1'b0}}, acc_q};
                        mplier_d    = bus.operand;
                        prod_d      = '0;
                        cnt_d       = CW'(WIDTH - 1);
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            prod_d   = prod_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
               state_d     = ST_IDLE;
               acc_d       = prod_next[WIDTH-1:0];
               carry_d     = |prod_next[2*WIDTH-1:WIDTH];
               ovf_d       = 1'b0;
               out_valid_d = 1'b1;
               wr_acc      = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_acc) begin
         zero_d = (acc_d == '0);
      end
   end

   // State, accumulator, flags and multiplier working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         zero_q      <= 1'b1;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         mplier_q    <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
         mplier_q    <= mplier_d;
      end
   end
endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed scenarios plus a randomized run against an
// arithmetic reference model. A second instance is built without the
// multiplier.
module tb_acc_alu;
   localparam int W = 16;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b110;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   busy2_seen = 1'b0;

   logic [15:0] m_acc;
   logic        m_z, m_c, m_v;

   acc_alu_if #(.WIDTH(W)) a_if ();
   acc_alu_if #(.WIDTH(W)) b_if ();

   acc_alu #(.WIDTH(W), .MUL_EN(1)) dut       (.clk(clk), .rst_n(rst_n), .bus(a_if));
   acc_alu #(.WIDTH(W), .MUL_EN(0)) dut_nomul (.clk(clk), .rst_n(rst_n), .bus(b_if));

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && b_if.busy) busy2_seen = 1'b1;

   function automatic void model_reset();
      m_acc = 16'h0; m_z = 1'b1; m_c = 1'b0; m_v = 1'b0;
   endfunction

   // Reference: plain integer arithmetic over the operation definitions.
   function automatic void model(input logic [2:0] o, input logic [15:0] b);
      int unsigned ua, ub, r;
      int          sa, sb, sr;
      longint unsigned p;
      ua = m_acc; ub = b;
      sa = $signed(m_acc); sb = $signed(b);
      case (o)
         3'd0: begin m_acc = 16'h0; m_c = 0; m_v = 0; m_z = 1; end
         3'd1: begin
            r = ua + ub; m_acc = r[15:0]; m_c = (r > 65535);
            sr = sa + sb; m_v = (sr > 32767) || (sr < -32768); m_z = (m_acc == 0);
         end
         3'd2: begin
            r = ua - ub; m_acc = r[15:0]; m_c = (ua < ub);
            sr = sa - sb; m_v = (sr > 32767) || (sr < -32768); m_z = (m_acc == 0);
         end
         3'd3: begin m_acc = b; m_c = 0; m_v = 0; m_z = (m_acc == 0); end
         3'd4: begin m_acc = m_acc & b; m_c = 0; m_v = 0; m_z = (m_acc == 0); end
         3'd5: begin m_acc = m_acc | b; m_c = 0; m_v = 0; m_z = (m_acc == 0); end
         3'd6: begin
            p = longint'(ua) * longint'(ub);
            m_acc = p[15:0]; m_c = ((p >> 16) != 0); m_v = 0; m_z = (m_acc == 0);
         end
         default: ;
      endcase
   endfunction

   // Present a command at a negedge, wait for in_ready, pass the accepting
   // edge and return at the next negedge with in_valid still asserted.
   task automatic send(input logic [2:0] o, input logic [15:0] b, output int stall);
      a_if.in_valid = 1'b1; a_if.op = o; a_if.operand = b;
      stall = 0;
      while (a_if.in_ready !== 1'b1 && stall < 64) begin
         @(negedge clk); stall++;
      end
      @(posedge clk);
      model(o, b);
      @(negedge clk);
   endtask

   task automatic idle();
      a_if.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      a_if.in_valid = 0; a_if.op = 0; a_if.operand = 0;
      b_if.in_valid = 0; b_if.op = 0; b_if.operand = 0;
      #2 rst_n = 1'b0;
      #3;
      n_cmp++;
      if ({a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid, a_if.busy, a_if.in_ready}
          !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: acc=%h z=%b c=%b v=%b ov=%b busy=%b rdy=%b, want acc=0000 z=1 c=0 v=0 ov=0 busy=0 rdy=1",
                  a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid, a_if.busy, a_if.in_ready);
      end
      n_cmp++;
      if ({b_if.acc_out, b_if.zero, b_if.out_valid, b_if.in_ready} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state_nomul: acc=%h z=%b ov=%b rdy=%b, want acc=0000 z=1 ov=0 rdy=1",
                  b_if.acc_out, b_if.zero, b_if.out_valid, b_if.in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      n_cmp++;
      if ({a_if.acc_out, a_if.zero, a_if.out_valid, a_if.in_ready} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL post_release_idle: acc=%h z=%b ov=%b rdy=%b, want acc=0000 z=1 ov=0 rdy=1",
                  a_if.acc_out, a_if.zero, a_if.out_valid, a_if.in_ready);
      end
   endtask

   task automatic test_add_sub();
      int s;
      send(OP_LOAD, 16'h7FFF, s);
      n_cmp++;
      if ({a_if.acc_out, a_if.out_valid} !== {16'h7FFF, 1'b1}) begin
         n_err++; $display("FAIL load_7fff: acc=%h ov=%b, want 7fff ov=1", a_if.acc_out, a_if.out_valid);
      end
      send(OP_ADD, 16'h0001, s);
      n_cmp++;
      if ({a_if.acc_out, a_if.overflow, a_if.carry, a_if.zero, a_if.out_valid} !== {16'h8000, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL add_overflow: acc=%h v=%b c=%b z=%b ov=%b, want 8000 v=1 c=0 z=0 ov=1",
                           a_if.acc_out, a_if.overflow, a_if.carry, a_if.zero, a_if.out_valid);
      end
      idle();
      n_cmp++;
      if ({a_if.out_valid, a_if.acc_out} !== {1'b0, 16'h8000}) begin
         n_err++; $display("FAIL single_pulse: ov=%b acc=%h, want ov=0 acc=8000", a_if.out_valid, a_if.acc_out);
      end
      send(OP_LOAD, 16'h0005, s);
      send(OP_SUB, 16'h0006, s);
      n_cmp++;
      if ({a_if.acc_out, a_if.carry, a_if.overflow, a_if.zero} !== {16'hFFFF, 1'b1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL sub_borrow: acc=%h c=%b v=%b z=%b, want ffff c=1 v=0 z=0",
                           a_if.acc_out, a_if.carry, a_if.overflow, a_if.zero);
      end
      send(OP_SUB, 16'hFFFF, s);
      n_cmp++;
      if ({a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL sub_to_zero: acc=%h z=%b c=%b v=%b, want 0000 z=1 c=0 v=0",
                           a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow);
      end
      idle();
   endtask

   task automatic test_mul();
      int s;
      send(OP_LOAD, 16'h0123, s);
      send(OP_MUL, 16'h0010, s);
      a_if.in_valid = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         n_cmp++;
         if ({a_if.in_ready, a_if.busy, a_if.out_valid, a_if.acc_out} !== {1'b0, 1'b1, 1'b0, 16'h0123}) begin
            n_err++; $display("FAIL mul_running cycle %0d: rdy=%b busy=%b ov=%b acc=%h, want rdy=0 busy=1 ov=0 acc=0123",
                              k, a_if.in_ready, a_if.busy, a_if.out_valid, a_if.acc_out);
         end
         @(negedge clk);
      end
      n_cmp++;
      if ({a_if.out_valid, a_if.in_ready, a_if.busy, a_if.acc_out, a_if.carry, a_if.zero}
          !== {1'b1, 1'b1, 1'b0, 16'h1230, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL mul_result: ov=%b rdy=%b busy=%b acc=%h c=%b z=%b, want ov=1 rdy=1 busy=0 acc=1230 c=0 z=0",
                           a_if.out_valid, a_if.in_ready, a_if.busy, a_if.acc_out, a_if.carry, a_if.zero);
      end
      // MUL with an ADD held on the bus while the multiply runs.
      send(OP_LOAD, 16'h8000, s);
      send(OP_MUL, 16'h0002, s);
      a_if.op = OP_ADD; a_if.operand = 16'h0005;
      for (int k = 1; k <= 16; k++) begin
         n_cmp++;
         if ({a_if.in_ready, a_if.acc_out} !== {1'b0, 16'h8000}) begin
            n_err++; $display("FAIL mul_hold_add cycle %0d: rdy=%b acc=%h, want rdy=0 acc=8000", k, a_if.in_ready, a_if.acc_out);
         end
         @(negedge clk);
      end
      n_cmp++;
      if ({a_if.out_valid, a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL mul_carry: ov=%b acc=%h z=%b c=%b v=%b, want ov=1 acc=0000 z=1 c=1 v=0",
                           a_if.out_valid, a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow);
      end
      @(posedge clk);
      model(OP_ADD, 16'h0005);
      @(negedge clk);
      a_if.in_valid = 1'b0;
      n_cmp++;
      if ({a_if.out_valid, a_if.acc_out, a_if.zero, a_if.carry} !== {1'b1, 16'h0005, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL add_after_mul: ov=%b acc=%h z=%b c=%b, want ov=1 acc=0005 z=0 c=0",
                           a_if.out_valid, a_if.acc_out, a_if.zero, a_if.carry);
      end
      idle();
      n_cmp++;
      if ({a_if.out_valid, a_if.acc_out} !== {1'b0, 16'h0005}) begin
         n_err++; $display("FAIL add_after_mul_once: ov=%b acc=%h, want ov=0 acc=0005", a_if.out_valid, a_if.acc_out);
      end
   endtask

   task automatic test_reset_during_mul();
      int s;
      send(OP_LOAD, 16'h1111, s);
      send(OP_MUL, 16'h0003, s);
      a_if.in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid, a_if.busy, a_if.in_ready}
          !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL mul_abort: acc=%h z=%b c=%b v=%b ov=%b busy=%b rdy=%b, want 0000 z=1 c=0 v=0 ov=0 busy=0 rdy=1",
                           a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid, a_if.busy, a_if.in_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({a_if.out_valid, a_if.in_ready, a_if.acc_out} !== {1'b0, 1'b1, 16'h0000}) begin
            n_err++; $display("FAIL after_abort cycle %0d: ov=%b rdy=%b acc=%h, want ov=0 rdy=1 acc=0000",
                              k, a_if.out_valid, a_if.in_ready, a_if.acc_out);
         end
      end
      send(OP_LOAD, 16'h00AA, s);
      n_cmp++;
      if ({s, a_if.acc_out, a_if.out_valid} !== {32'd0, 16'h00AA, 1'b1}) begin
         n_err++; $display("FAIL accept_after_abort: stall=%0d acc=%h ov=%b, want stall=0 acc=00aa ov=1",
                           s, a_if.acc_out, a_if.out_valid);
      end
      idle();
   endtask

   task automatic test_mul_disabled();
      @(negedge clk);
      b_if.in_valid = 1'b1; b_if.op = OP_LOAD; b_if.operand = 16'h0003;
      @(posedge clk); @(negedge clk);
      b_if.op = OP_MUL; b_if.operand = 16'h0004;
      @(posedge clk); @(negedge clk);
      b_if.in_valid = 1'b0;
      n_cmp++;
      if ({b_if.acc_out, b_if.out_valid, b_if.busy, b_if.in_ready} !== {16'h0003, 1'b1, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL nomul_mul_is_nop: acc=%h ov=%b busy=%b rdy=%b, want 0003 ov=1 busy=0 rdy=1",
                           b_if.acc_out, b_if.out_valid, b_if.busy, b_if.in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if ({b_if.out_valid, busy2_seen} !== {1'b0, 1'b0}) begin
         n_err++; $display("FAIL nomul_busy: ov=%b busy_seen=%b, want ov=0 busy_seen=0", b_if.out_valid, busy2_seen);
      end
   endtask

   task automatic test_random();
      int s, n;
      logic [2:0]  o;
      logic [15:0] b;
      for (int i = 0; i < 150; i++) begin
         o = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: b = 16'h0000;
            1: b = 16'hFFFF;
            2: b = 16'h8000;
            3: b = 16'h7FFF;
            default: b = 16'($urandom);
         endcase
         send(o, b, s);
         if (o == OP_MUL) begin
            a_if.in_valid = 1'b0;
            n = 1;
            while (a_if.out_valid !== 1'b1 && n < 40) begin
               @(negedge clk); n++;
            end
            n_cmp++;
            if (n !== 17) begin
               n_err++; $display("FAIL rand_mul_latency #%0d: got %0d cycles, want 17", i, n);
            end
         end
         n_cmp++;
         if ({a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid} !== {m_acc, m_z, m_c, m_v, 1'b1}) begin
            n_err++; $display("FAIL rand_op #%0d op=%0d b=%h: acc=%h z=%b c=%b v=%b ov=%b, want acc=%h z=%b c=%b v=%b ov=1",
                              i, o, b, a_if.acc_out, a_if.zero, a_if.carry, a_if.overflow, a_if.out_valid,
                              m_acc, m_z, m_c, m_v);
         end
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_reset_during_mul();
      test_mul_disabled();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule

// File: doc/acc_alu.md
ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the accumulator, operand and result width (legal range 4..64).
REQ-002 Parameter MUL_EN, default 1, SHALL include (1) or exclude (0) the multi-cycle multiply unit.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark that op and operand hold a valid command.
REQ-006 in_ready  output  1  SHALL mark that the block can accept a command this cycle.
REQ-007 op  input  3  SHALL select the operation: 000 CLR, 001 ADD, 010 SUB, 011 LOAD, 100 AND, 101 OR, 110 MUL, 111 NOP.
REQ-008 operand  input  WIDTH  SHALL carry the B operand; the accumulator is the A operand.
REQ-009 acc_out  output  WIDTH  SHALL drive the registered accumulator value.
REQ-010 out_valid  output  1  SHALL pulse high for one cycle when a command result lands in acc_out.
REQ-011 zero, carry, overflow  output  1 each  SHALL drive the registered status flags.
REQ-012 busy  output  1  SHALL be high while a multiply is in progress.

Function
REQ-013 Acceptance SHALL occur on a rising edge where in_valid && in_ready; no backpressure on out_valid.
REQ-014 The FSM SHALL have two states, IDLE and MUL; in_ready = (state == IDLE); busy = (state == MUL).
REQ-015 A single-cycle op (everything except MUL with MUL_EN=1) SHALL update acc_out and the flags on the accepting edge, with out_valid high the following cycle; latency 1.
REQ-016 CLR: acc=0.
REQ-017 ADD: acc = acc + operand mod 2^WIDTH; carry = unsigned carry-out; overflow = signed two's-complement overflow.
REQ-018 SUB: acc = acc - operand mod 2^WIDTH; carry = borrow (acc < operand, unsigned); overflow = signed overflow.
REQ-019 LOAD: acc = operand.
REQ-020 AND/OR: acc = bitwise result.
REQ-021 NOP: acc SHALL be held; out_valid SHALL still pulse.
REQ-022 CLR, LOAD, AND, OR SHALL set carry=0 and overflow=0; NOP SHALL hold all flags.
REQ-023 zero SHALL equal (new acc == 0) for every op that writes acc.
REQ-024 MUL with MUL_EN=1 SHALL move IDLE->MUL and latch the multiplicand (acc) and multiplier (operand).
REQ-025 MUL SHALL perform shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, using a counter of $clog2(WIDTH)+1 bits.
REQ-026 On the last MUL cycle, acc SHALL take the low WIDTH bits of the product, the state SHALL return to IDLE, and out_valid SHALL pulse the next cycle; total latency WIDTH+1 cycles from acceptance.
REQ-027 MUL SHALL set carry=1 if the upper WIDTH product bits are nonzero, set overflow=0, and update zero.
REQ-028 acc_out and the flags SHALL hold their pre-MUL values while in MUL.
REQ-029 in_valid during MUL SHALL be ignored; the source holds the command until in_ready.
REQ-030 MUL with MUL_EN=0 SHALL behave as NOP.
REQ-031 A command SHALL be acceptable in the IDLE cycle immediately after MUL completes, back-to-back with out_valid.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, acc_out=0, zero=1, carry=0, overflow=0, out_valid=0, busy=0, and the MUL counter and working registers to 0.
REQ-033 Reset during MUL SHALL abort it with no out_valid pulse; in_ready SHALL be 1 on the first edge after release.

Verification (WIDTH=16, MUL_EN=1)
REQ-034 Reset release, then LOAD 0x7FFF, then ADD 0x0001 -> acc_out 0x8000, overflow=1, carry=0, zero=0; one out_valid pulse per command.
REQ-035 LOAD 0x0005, SUB 0x0006 -> acc_out 0xFFFF, carry=1, overflow=0; then SUB 0xFFFF -> acc_out 0x0000, zero=1.
REQ-036 LOAD 0x0123, MUL 0x0010 -> in_ready low for 16 cycles, acc_out 0x1230 with out_valid 17 cycles after acceptance, carry=0.
REQ-037 LOAD 0x8000, MUL 0x0002 -> acc_out 0x0000, zero=1, carry=1; in_valid with ADD held during MUL is accepted only after return to IDLE.
REQ-038 rst_n pulsed low at MUL cycle 8 -> acc_out 0, zero=1, no out_valid, in_ready=1 after release.
REQ-039 MUL_EN=0 build: LOAD 0x0003, MUL 0x0004 -> acc_out 0x0003, out_valid one cycle later, busy never high.
